dpi_flow_ctx_sched: RTL and testbench

Per-flow context scheduler sitting directly upstream of a DFA regex matcher stage. It accepts framed payload bytes tagged with a flow ID, restores that flow's saved DFA state into the matcher, streams the packet's bytes into the matcher, and writes the matcher's final state back to a per-flow context table. This lets one matcher scan interleaved flows. At end of packet it reports a per-packet match summary downstream.

---
 rtl/dpi_flow_ctx_sched.sv | 154 +++++++++++++++
 tb/tb_dpi_flow_ctx_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dpi_flow_ctx_sched.sv
// dpi_flow_ctx_sched
// Per-flow DFA context scheduler in front of a single regex matcher. It
// restores a flow's saved DFA state into the matcher at start of packet,
// streams the payload bytes, then writes the matcher's final state back to
// the context table and emits a per-packet match summary.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   pkt_*               framed payload input (vld/rdy handshake, sop/eop)
//   clr_vld/clr_flow    request to zero one flow's context, held until clr_ack
//   clr_ack             one-cycle pulse when the clear is performed
//   m_char*/m_state*    drive the matcher char and state-restore inputs
//   m_state_out         matcher current state, written back at end of packet
//   m_accept            matcher accept for the byte presented this cycle
//   res_*               one-cycle packet summary (flow, any-match, length)
module dpi_flow_ctx_sched #(
    parameter int FLOW_W  = 4,
    parameter int STATE_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pkt_vld,
    input  logic               pkt_sop,
    input  logic               pkt_eop,
    input  logic [FLOW_W-1:0]  pkt_flow,
    input  logic [7:0]         pkt_byte,
    output logic               pkt_rdy,
    input  logic               clr_vld,
    input  logic [FLOW_W-1:0]  clr_flow,
    output logic               clr_ack,
    output logic [7:0]         m_char,
    output logic               m_char_vld,
    output logic [STATE_W-1:0] m_state,
    output logic               m_state_vld,
    input  logic [STATE_W-1:0] m_state_out,
    input  logic               m_accept,
    output logic               res_vld,
    output logic [FLOW_W-1:0]  res_flow,
    output logic               res_match,
    output logic [15:0]        res_len
);
    localparam int DEPTH = 1 << FLOW_W;

    typedef enum logic [2:0] {INIT, IDLE, LOAD, STREAM, SAVE} state_t;

    state_t             state;
    logic [STATE_W-1:0] ctx [DEPTH];
    logic [FLOW_W-1:0]  sweep;
    logic [FLOW_W-1:0]  flow;
    logic               acc_match;
    logic [15:0]        acc_len;
    logic [15:0]        len_nxt;
    logic               take;

    logic               wr_en;
    logic [FLOW_W-1:0]  wr_addr;
    logic [STATE_W-1:0] wr_data;

    // Handshake and matcher char path are combinational so a byte reaches
    // the matcher in the same cycle it is consumed.
    assign pkt_rdy    = (state == STREAM);
    assign take       = pkt_rdy && pkt_vld;
    assign m_char_vld = take;
    assign m_char     = pkt_rdy ? pkt_byte : 8'h00;
    // Ack is combinational so the requester sees it in the cycle the write
    // lands and can drop clr_vld before a second clear would be performed.
    assign clr_ack    = (state == IDLE) && clr_vld;

    assign len_nxt = (acc_len == 16'hFFFF) ? acc_len : acc_len + 16'd1;

    // Single table write port shared by the init sweep, clears and save-back.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (rst_n) begin
            case (state)
                INIT: begin
                    wr_en   = 1'b1;
                    wr_addr = sweep;
                end
                IDLE: begin
                    wr_en   = clr_vld;
                    wr_addr = clr_flow;
                end
                SAVE: begin
                    wr_en   = 1'b1;
                    wr_addr = flow;
                    wr_data = m_state_out;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) ctx[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= INIT;
            sweep       <= '0;
            flow        <= '0;
            acc_match   <= 1'b0;
            acc_len     <= '0;
            m_state     <= '0;
            m_state_vld <= 1'b0;
            res_vld     <= 1'b0;
            res_flow    <= '0;
            res_match   <= 1'b0;
            res_len     <= '0;
        end else begin
            m_state_vld <= 1'b0;
            res_vld     <= 1'b0;
            case (state)
                INIT: begin
                    sweep <= sweep + 1'b1;
                    if (&sweep) state <= IDLE;
                end
                IDLE: begin
                    // No table write happens on a sop-accept cycle (clear
                    // wins), so reading ctx here equals the LOAD-cycle value.
                    if (!clr_vld && pkt_vld && pkt_sop) begin
                        flow        <= pkt_flow;
                        acc_match   <= 1'b0;
                        acc_len     <= '0;
                        m_state     <= ctx[pkt_flow];
                        m_state_vld <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: state <= STREAM;
                STREAM: begin
                    if (take) begin
                        acc_match <= acc_match | m_accept;
                        acc_len   <= len_nxt;
                        if (pkt_eop) begin
                            // Summary is registered here so it is valid in SAVE
                            // and already includes the eop byte.
                            res_vld   <= 1'b1;
                            res_flow  <= flow;
                            res_match <= acc_match | m_accept;
                            res_len   <= len_nxt;
                            state     <= SAVE;
                        end
                    end
                end
                SAVE:    state <= IDLE;
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_dpi_flow_ctx_sched.sv
// Bench for dpi_flow_ctx_sched with a behavioural matcher: next state is
// state + byte (11-bit wrap); accept when the presented byte is 8'hAA.
module tb_dpi_flow_ctx_sched;
    logic        clk = 0, rst_n = 0;
    logic        pkt_vld = 0, pkt_sop = 0, pkt_eop = 0;
    logic [3:0]  pkt_flow = 0;
    logic [7:0]  pkt_byte = 0;
    logic        pkt_rdy;
    logic        clr_vld = 0;
    logic [3:0]  clr_flow = 0;
    logic        clr_ack;
    logic [7:0]  m_char;
    logic        m_char_vld;
    logic [10:0] m_state;
    logic        m_state_vld;
    logic [10:0] m_state_out;
    logic        m_accept;
    logic        res_vld;
    logic [3:0]  res_flow;
    logic        res_match;
    logic [15:0] res_len;

    always #5 clk = ~clk;

    dpi_flow_ctx_sched #(.FLOW_W(4), .STATE_W(11)) dut (
        .clk(clk), .rst_n(rst_n),
        .pkt_vld(pkt_vld), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
        .pkt_flow(pkt_flow), .pkt_byte(pkt_byte), .pkt_rdy(pkt_rdy),
        .clr_vld(clr_vld), .clr_flow(clr_flow), .clr_ack(clr_ack),
        .m_char(m_char), .m_char_vld(m_char_vld),
        .m_state(m_state), .m_state_vld(m_state_vld),
        .m_state_out(m_state_out), .m_accept(m_accept),
        .res_vld(res_vld), .res_flow(res_flow), .res_match(res_match),
        .res_len(res_len)
    );

    // matcher model
    logic [10:0] st = '0;
    assign m_state_out = st;
    assign m_accept    = m_char_vld && (m_char == 8'hAA);
    always @(posedge clk) begin
        if (m_state_vld)     st <= m_state;
        else if (m_char_vld) st <= st + {3'b000, m_char};
    end

    int pass_cnt = 0, total = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // scoreboard
    logic [10:0] load_q[$];
    logic [20:0] res_q[$];
    int load_cyc = 0, res_cyc = 0, rdy_cyc = -1, ack_cyc = 0, ack_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_state_vld) begin
                load_cyc = cyc;
                if (load_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_load: got m_state %0h, none expected", m_state);
                end else chk("load_state", m_state, load_q.pop_front());
            end
            if (res_vld) begin
                res_cyc = cyc;
                if (res_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_res: got flow %0d len %0d, none expected", res_flow, res_len);
                end else chk("res_summary", {res_flow, res_match, res_len}, res_q.pop_front());
            end
            if (m_state_vld && m_char_vld) chk("vld_exclusive", 1, 0);
            if (pkt_rdy && rdy_cyc < 0) rdy_cyc = cyc;
            if (clr_ack) begin
                ack_cnt++;
                ack_cyc = cyc;
            end
        end
    end

    task automatic send_pkt(input logic [3:0] f, input int len, input logic [5:0][7:0] b,
                            input int gap_at, input logic [10:0] eload, input logic ematch);
        int i = 0, n = 0;
        logic r;
        load_q.push_back(eload);
        res_q.push_back({f, ematch, 16'(len)});
        pkt_flow = f;
        while (i < len && n < 100) begin
            pkt_vld  = 1;
            pkt_sop  = (i == 0);
            pkt_eop  = (i == len - 1);
            pkt_byte = b[i];
            @(negedge clk);
            r = pkt_rdy;
            @(posedge clk); #1;
            n++;
            if (r) begin
                i++;
                if (i == gap_at) begin
                    pkt_vld = 0;
                    for (int g = 0; g < 3; g++) begin
                        @(negedge clk);
                        chk("gap_idle", {m_char_vld, m_state_vld, pkt_rdy}, 3'b001);
                        @(posedge clk); #1;
                    end
                end
            end
        end
        pkt_vld = 0; pkt_sop = 0; pkt_eop = 0;
        if (i < len) begin
            total++;
            $display("FAIL send_timeout: consumed %0d of %0d bytes", i, len);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (res_q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (res_q.size() != 0) begin
            total++;
            $display("FAIL res_timeout: %0d results outstanding, 0 required", res_q.size());
        end
    endtask

    typedef struct {
        logic [3:0]      flow;
        int              len;
        logic [5:0][7:0] b;
        int              gap_at;
        logic [10:0]     load;
        logic            match;
    } vec_t;
    vec_t v[7];

    task automatic set_vec(input int k, input logic [3:0] f, input int len,
                           input logic [7:0] b0, b1, b2, b3, b4, b5,
                           input int gap_at, input logic [10:0] load, input logic match);
        v[k].flow = f; v[k].len = len; v[k].gap_at = gap_at;
        v[k].load = load; v[k].match = match;
        v[k].b[0] = b0; v[k].b[1] = b1; v[k].b[2] = b2;
        v[k].b[3] = b3; v[k].b[4] = b4; v[k].b[5] = b5;
    endtask

    int r0, s;
    logic [5:0][7:0] bb;

    initial begin
        //          flow len bytes                                gap load    match
        set_vec(0, 3, 5, 8'h01, 8'h01, 8'h01, 8'hAA, 8'h01, 8'h00, 0, 11'h000, 1); // flow3 -> 0xAE
        set_vec(1, 2, 2, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 0, 11'h000, 0); // flow2 -> 7
        set_vec(2, 5, 3, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 0, 11'h000, 0); // flow5 -> 6
        set_vec(3, 2, 1, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 11'h007, 0); // flow2 -> 9
        set_vec(4, 1, 1, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 11'h000, 0); // flow1 -> 5
        set_vec(5, 3, 4, 8'hAA, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 2, 11'h0AE, 1); // 3-cycle gap
        set_vec(6, 5, 6, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 0, 11'h006, 0);

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {pkt_rdy, clr_ack, m_char_vld, m_state_vld, res_vld}, 5'b0);
        chk("reset_data", {m_char, m_state, res_flow, res_match, res_len}, 0);

        // init sweep length: sop pending from release, LOAD only after 16 INIT cycles
        @(posedge clk); #1;
        rst_n = 1;
        r0 = cyc;
        rdy_cyc = -1;
        bb = '0; bb[0] = 8'h11;
        send_pkt(4'd0, 1, bb, 0, 11'h000, 1'b0);
        drain();
        chk("init_load_latency", load_cyc - r0, 17);
        chk("init_rdy_latency", rdy_cyc - r0, 18);

        for (int k = 0; k < 7; k++) begin
            send_pkt(v[k].flow, v[k].len, v[k].b, v[k].gap_at, v[k].load, v[k].match);
            drain();
        end

        // single-byte packet latency from sop seen in IDLE
        repeat (3) begin @(posedge clk); #1; end
        s = cyc;
        bb = '0; bb[0] = 8'h09;
        send_pkt(4'd1, 1, bb, 0, 11'h005, 1'b0);
        drain();
        chk("single_res_latency", res_cyc - s, 3);

        // clear of flow 2 (holding 9) wins over a simultaneous sop for flow 2
        repeat (2) begin @(posedge clk); #1; end
        s = cyc;
        ack_cnt = 0;
        clr_flow = 4'd2;
        clr_vld = 1;
        bb = '0; bb[0] = 8'hAA;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    if (clr_ack) break;
                end
                @(posedge clk); #1;
                clr_vld = 0;
            end
            send_pkt(4'd2, 1, bb, 0, 11'h000, 1'b1);
        join
        drain();
        chk("clr_ack_count", ack_cnt, 1);
        chk("clr_ack_cycle", ack_cyc - s, 0);
        chk("clr_then_load", load_cyc - s, 2);

        chk("load_q_empty", load_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
